// File: rtl/pipelined_mux_n.sv
// pipelined_mux_n: N-input, WIDTH-bit channel selector with a one-entry
// registered output stage and valid/ready flow control on every channel.
// Optional round-robin arbitration is compiled in when PIPELINED_MUX_RR_EN
// is defined. Without it, the mode port is ignored and sel always chooses
// the channel.
//
// Handshake semantics: a word moves across a channel on a rising edge where
// that channel's valid and ready are both high. The producer holds data
// stable while valid is high and ready is low. in_ready is combinational
// from sel/mode/in_valid/out_ready/state and never depends on in_data.
// out_valid/out_data/out_sel come straight from registers.
module pipelined_mux_n #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    // Output-stage state; out_valid is a direct view of it.
    state_t state;

    logic [WIDTH-1:0] ch [N];
    logic             can_accept;
    logic             sel_ok;
    logic             grant_ok;
    logic [SEL_W-1:0] g;
    logic             in_xfer;

    // Unpack the flat data bus into per-channel words.
    for (genvar k = 0; k < N; k++) begin : g_unpack
        assign ch[k] = in_data[k*WIDTH +: WIDTH];
    end

    // The stage can take a word when empty or when the held word leaves now.
    assign can_accept = !reset && ((state == EMPTY) || out_ready);
    // Select values at or above N name no channel (non power-of-two N).
    assign sel_ok     = (int'(sel) < N);
    assign out_valid  = (state == FULL);

`ifdef PIPELINED_MUX_RR_EN
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_g;
    logic             rr_found;

    // Round-robin scan: first valid channel starting at ptr, wrapping at N.
    always_comb begin
        int               pos;
        logic [SEL_W-1:0] idx;
        rr_g     = '0;
        rr_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) pos = pos - N;
            idx = SEL_W'(pos);
            if (!rr_found && in_valid[idx]) begin
                rr_g     = idx;
                rr_found = 1'b1;
            end
        end
    end

    // Grant source: round-robin scan in mode 1, explicit sel in mode 0.
    always_comb begin
        g        = sel;
        grant_ok = sel_ok;
        if (mode) begin
            g        = rr_g;
            grant_ok = rr_found;
        end
    end

    // Pointer advances past the channel just served; only in RR mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (in_xfer && mode) begin
            ptr <= (g == SEL_W'(N-1)) ? '0 : g + 1'b1;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    // Grant source: always the explicit select.
    always_comb begin
        g        = sel;
        grant_ok = sel_ok;
    end
`endif

    // Only the granted channel sees ready, and only when the stage can accept.
    always_comb begin
        in_ready = '0;
        if (grant_ok && can_accept) in_ready[g] = 1'b1;
    end

    assign in_xfer = grant_ok && can_accept && in_valid[g];

    // Output stage: load on input transfer, drain to EMPTY on a lone output transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            out_data <= '0;
            out_sel  <= '0;
        end else if (in_xfer) begin
            state    <= FULL;
            out_data <= ch[g];
            out_sel  <= g;
        end else if ((state == FULL) && out_ready) begin
            state    <= EMPTY;
        end
    end

endmodule

// File: tb/tb_pipelined_mux_n.sv
// tb_pipelined_mux_n: directed and randomized checks of pipelined_mux_n
// against a cycle-level behavioural model (grant found by a modulo scan,
// one-word register with full flag). A small N=3 instance covers sel >= N.
// Round-robin steps are compiled when PIPELINED_MUX_RR_EN is defined.
module tb_pipelined_mux_n;
    localparam int W = 32;
    localparam int N = 4;
`ifdef PIPELINED_MUX_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic [1:0]     sel;
    logic           mode;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;

    logic [2:0]     r3_in_valid;
    logic [2:0]     r3_in_ready;
    logic [23:0]    r3_in_data;
    logic [1:0]     r3_sel;
    logic           r3_mode;
    logic           r3_out_valid;
    logic           r3_out_ready;
    logic [7:0]     r3_out_data;
    logic [1:0]     r3_out_sel;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit         m_full;
    logic [W-1:0] m_data;
    int         m_sel;
    int         m_ptr;

    always #5 clk = ~clk;

    pipelined_mux_n #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sel(sel), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel)
    );

    pipelined_mux_n #(.WIDTH(8), .N(3)) dut3 (
        .clk(clk), .reset(reset),
        .in_valid(r3_in_valid), .in_ready(r3_in_ready), .in_data(r3_in_data),
        .sel(r3_sel), .mode(r3_mode),
        .out_valid(r3_out_valid), .out_ready(r3_out_ready),
        .out_data(r3_out_data), .out_sel(r3_out_sel)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (RR_EN && mode) begin
            for (int i = 0; i < N; i++) begin
                if (in_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
            end
            return -1;
        end
        return (int'(sel) < N) ? int'(sel) : -1;
    endfunction

    task automatic set_ch(input int k, input logic [W-1:0] v);
        in_data[k*W +: W] = v;
    endtask

    // One clock: check in_ready against the model, advance model, check outputs.
    task automatic cycle();
        int           g;
        bit           acc;
        logic [N-1:0] exp_rdy;
        #1;
        g       = model_grant();
        acc     = !reset && (!m_full || out_ready);
        exp_rdy = (g >= 0 && acc) ? (N'(1) << g) : '0;
        check("in_ready", in_ready, exp_rdy);
        if (reset) begin
            m_full = 0; m_data = '0; m_sel = 0; m_ptr = 0;
        end else if (g >= 0 && acc && in_valid[g]) begin
            m_data = in_data[g*W +: W];
            m_sel  = g;
            m_full = 1;
            if (RR_EN && mode) m_ptr = (g + 1) % N;
        end else if (m_full && out_ready) begin
            m_full = 0;
        end
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_full);
        if (m_full || reset) begin
            check("out_data", out_data, m_data);
            check("out_sel", out_sel, m_sel);
        end
    endtask

    initial begin
        int exp_seq[$];
        reset = 1'b1; in_valid = '0; in_data = '0; sel = '0; mode = 1'b0; out_ready = 1'b0;
        r3_in_valid = '0; r3_in_data = '0; r3_sel = '0; r3_mode = 1'b0; r3_out_ready = 1'b1;
        m_full = 0; m_data = '0; m_sel = 0; m_ptr = 0;

        // Reset
        cycle();
        cycle();
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_sel", out_sel, 2'd0);
        check("rst_r3_valid", r3_out_valid, 1'b0);
        reset = 1'b0;

        // N=3 instance: sel=3 names no channel
        r3_sel = 2'd3; r3_in_valid = 3'b111; r3_in_data = 24'hC3B2A1;
        #1;
        check("r3_sel3_rdy", r3_in_ready, 3'b000);
        cycle();
        check("r3_sel3_valid", r3_out_valid, 1'b0);
        r3_sel = 2'd2; r3_in_data = 24'hA5B2A1;
        #1;
        check("r3_sel2_rdy", r3_in_ready, 3'b100);
        cycle();
        check("r3_sel2_valid", r3_out_valid, 1'b1);
        check("r3_sel2_data", r3_out_data, 8'hA5);
        check("r3_sel2_sel", r3_out_sel, 2'd2);
        r3_in_valid = '0;

        // Explicit select, single word
        sel = 2'd2; in_valid = 4'b0100; set_ch(2, 32'hDEADBEEF); out_ready = 1'b1;
        #1;
        check("t1_rdy", in_ready, 4'b0100);
        cycle();
        check("t1_valid", out_valid, 1'b1);
        check("t1_data", out_data, 32'hDEADBEEF);
        check("t1_sel", out_sel, 2'd2);

        // Backpressure
        sel = 2'd1; in_valid = 4'b0010; set_ch(1, 32'h1111_1111);
        cycle();
        out_ready = 1'b0; sel = 2'd3; in_valid = 4'b1000; set_ch(3, 32'h3333_3333);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("bp_rdy", in_ready, 4'b0000);
            check("bp_hold", out_data, 32'h1111_1111);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", in_ready, 4'b1000);
        cycle();
        check("bp_load_data", out_data, 32'h3333_3333);
        check("bp_load_sel", out_sel, 2'd3);

        // Streaming, no bubbles
        sel = 2'd0; in_valid = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            set_ch(0, W'(i));
            cycle();
            check("stream_valid", out_valid, 1'b1);
            check("stream_data", out_data, 64'(i));
        end
        in_valid = '0;
        cycle();
        check("drain_valid", out_valid, 1'b0);

`ifdef PIPELINED_MUX_RR_EN
        // Round-robin sequences
        for (int k = 0; k < N; k++) set_ch(k, 32'hA0 + k);
        mode = 1'b1; in_valid = 4'b1111;
        exp_seq = '{0, 1, 2, 3, 0};
        foreach (exp_seq[i]) begin
            cycle();
            check("rr_all_sel", out_sel, 64'(exp_seq[i]));
        end
        in_valid = 4'b1010;
        exp_seq = '{1, 3, 1, 3};
        foreach (exp_seq[i]) begin
            cycle();
            check("rr_1010_sel", out_sel, 64'(exp_seq[i]));
        end
        in_valid = 4'b0100;
        cycle();
        check("rr_to_ptr3", out_sel, 2'd2);
        in_valid = 4'b1001;
        cycle();
        check("rr_wrap_g3", out_sel, 2'd3);
        cycle();
        check("rr_wrap_g0", out_sel, 2'd0);
        mode = 1'b0;
`else
        // Mode is ignored without the round-robin arbiter
        mode = 1'b1; sel = 2'd2; in_valid = 4'b1111; set_ch(2, 32'h2222_2222);
        #1;
        check("mode_ignored_rdy", in_ready, 4'b0100);
        cycle();
        check("mode_ignored_sel", out_sel, 2'd2);
        mode = 1'b0;
`endif

        // Reset while FULL and stalled
        sel = 2'd1; in_valid = 4'b0010; set_ch(1, 32'h5555_AAAA); out_ready = 1'b1;
        cycle();
        check("pre_rst_valid", out_valid, 1'b1);
        out_ready = 1'b0; reset = 1'b1;
        #1;
        check("rst_rdy", in_ready, 4'b0000);
        cycle();
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_data", out_data, 32'h0);
        check("rst_mid_sel", out_sel, 2'd0);
        reset = 1'b0;
`ifdef PIPELINED_MUX_RR_EN
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        cycle();
        check("rr_after_rst", out_sel, 2'd0);
        mode = 1'b0;
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            in_valid  = N'($urandom_range(0, 15));
            sel       = 2'($urandom_range(0, 3));
            mode      = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 31) == 0);
            for (int k = 0; k < N; k++) set_ch(k, $urandom);
            cycle();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
